// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the fixed-timing ALU result with buffered load results onto the single register-file write port.
// Loads that lose arbitration wait in a small FIFO, and a newer ALU write to the same register kills them.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XZR   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [63:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_reg,
  input  logic [63:0] ld_data,
  input  logic [4:0]  query_reg1,
  input  logic [4:0]  query_reg2,
  output logic        pend1,
  output logic        pend2,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [4:0]    ZR   = 5'(XZR);

  logic [4:0]       entry_reg  [DEPTH];
  logic [63:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_live;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic alu_wr;
  logic ld_acc;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;
  logic push_live;

  assign fifo_empty = (count == '0);
  assign ld_ready   = !reset && (count != FULL);
  assign alu_wr     = alu_valid && (alu_reg != ZR);
  assign ld_acc     = ld_valid && ld_ready;
  assign pop        = !alu_wr && !fifo_empty;
  assign bypass     = !alu_wr && fifo_empty && ld_acc && (ld_reg != ZR);
  // Loads to XZR are simply consumed; they never take a FIFO slot.
  assign push       = ld_acc && (ld_reg != ZR) && (alu_wr || !fifo_empty);
  // A load pushed alongside an ALU write to the same register is already stale.
  assign push_live  = !(alu_wr && (ld_reg == alu_reg));

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live[i] && (entry_reg[i] == query_reg1) && (query_reg1 != ZR)) pend1 = 1'b1;
      if (entry_live[i] && (entry_reg[i] == query_reg2) && (query_reg2 != ZR)) pend2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      entry_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i]  <= '0;
        entry_data[i] <= '0;
      end
    end else begin
      if (alu_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entry_reg[i] == alu_reg) entry_live[i] <= 1'b0;
        end
      end

      if (pop) begin
        entry_live[rd_ptr] <= 1'b0;
        rd_ptr             <= rd_ptr + 1'b1;
      end

      if (push) begin
        entry_reg[wr_ptr]  <= ld_reg;
        entry_data[wr_ptr] <= ld_data;
        entry_live[wr_ptr] <= push_live;
        wr_ptr             <= wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (alu_wr) begin
      RegWrite      <= 1'b1;
      WriteRegister <= alu_reg;
      WriteData     <= alu_data;
    end else if (pop) begin
      // A killed head still drains, but produces no write.
      RegWrite <= entry_live[rd_ptr];
      if (entry_live[rd_ptr]) begin
        WriteRegister <= entry_reg[rd_ptr];
        WriteData     <= entry_data[rd_ptr];
      end
    end else if (bypass) begin
      RegWrite      <= 1'b1;
      WriteRegister <= ld_reg;
      WriteData     <= ld_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-stage arbiter directly upstream of the 32x64 register file; sole driver of its WriteData / WriteRegister / RegWrite.
- Merges two result sources onto the single write port: the ALU pipe (fixed timing, cannot stall) and the multi-cycle load unit (valid/ready handshake).
- Buffers load results that lose arbitration, kills stale buffered loads overtaken by newer ALU writes, and reports pending load destinations to the hazard unit.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of 2, >= 2)
- XZR, 31, register index whose writes are discarded

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_reg  in  5  ALU destination register
- alu_data  in  64  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  arbiter accepts load this cycle
- ld_reg  in  5  load destination register
- ld_data  in  64  load data
- query_reg1  in  5  hazard-unit source register 1
- query_reg2  in  5  hazard-unit source register 2
- pend1  out  1  live buffered load targets query_reg1
- pend2  out  1  live buffered load targets query_reg2
- RegWrite  out  1  regfile write enable, registered
- WriteRegister  out  5  regfile write index, registered
- WriteData  out  64  regfile write data, registered

Behaviour:
- One clock domain, posedge clk. Reset is synchronous, active-high; all state updates only on the clock edge.
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0; FIFO count=0, rd/wr ptr=0, all entry live bits=0. ld_ready=0 while reset is high.
- Outside reset: ld_ready = (count != DEPTH), combinational. It is never dependent on ld_valid.
- A load is accepted when ld_valid && ld_ready.
- Writes to XZR: an ALU write to XZR is treated as alu_valid=0. An accepted load to XZR is consumed and never written.
- Per-cycle selection, evaluated in priority order; the selected result is registered onto the regfile port at the next edge (1-cycle latency):
  1. alu_valid && alu_reg!=XZR: write the ALU result.
  2. Else if count>0: pop the head. If the head is live, write it; if dead, RegWrite=0 that cycle.
  3. Else if a load is accepted and ld_reg!=XZR: bypass it straight to the port, with no FIFO entry.
  4. Else: RegWrite=0. WriteRegister and WriteData hold their previous values.
- Push: an accepted load not bypassed (cases 1 or 2) is written at wr ptr with live=1, and wr ptr advances (mod DEPTH).
- Simultaneous push and pop is permitted (count unchanged). Because ld_ready is based on the current count, no push ever occurs while count==DEPTH.
- Staleness kill: an ALU write to R clears the live bit of every FIFO entry with reg==R, including an entry pushed the same cycle.
  - Loads always complete in program order before any concurrently presented ALU result, so buffered loads are always older.
  - Killed entries still occupy slots until popped.
- pend1 / pend2: combinational OR over live FIFO entries of (entry.reg==query_regN). They exclude the bypass path and are always 0 for query XZR.
- Pointers wrap modulo DEPTH. count range is 0..DEPTH.
- Reset mid-operation discards all buffered loads with no write issued. A load offered during reset is not accepted.

Test Plan:
- Reset, then one idle cycle: RegWrite=0, WriteRegister=0, WriteData=0, ld_ready=1, pend1=pend2=0.
- ALU-only stream: alu_reg=5, alu_data=0xA5 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xA5. alu_reg=31 -> RegWrite=0.
- Contention: alu (3, 0x11) and load (7, 0x22) in the same cycle -> cycle+1 writes X3 = 0x11; pend1=1 while query_reg1=7; cycle+2 writes X7 = 0x22; pend1=0.
- Fill: alu_valid held high for 6 cycles while loads to X1..X6 are offered -> ld_ready drops after 4 accepts; with ALU released, X1..X4 are written in order on consecutive cycles, then X5 and X6 are accepted.
- Kill: buffer a load (9, 0xBEEF), then ALU write (9, 0xCAFE) -> X9 = 0xCAFE is written; the later pop of the dead entry gives RegWrite=0, so X9 is never 0xBEEF.
- Reset with 3 entries buffered -> next cycles RegWrite=0, count=0, ld_ready=1, pend outputs 0.
